// File: rtl/wb_slave_interface_pkg.sv
// Shared encodings for the Wishbone responder: FSM states, termination kinds
// and a state-name decode used only when debug visibility is enabled.
package wb_slave_interface_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RESP    = 2'd2,
    RECOVER = 2'd3
  } state_e;

  typedef enum logic {
    ACK = 1'b0,
    ERR = 1'b1
  } term_e;

  function automatic logic [55:0] state_name(input state_e s);
    logic [55:0] name;
    case (s)
      IDLE:    name = {24'h0, "IDLE"};
      REQ:     name = {32'h0, "REQ"};
      RESP:    name = {24'h0, "RESP"};
      RECOVER: name = "RECOVER";
      default: name = '0;
    endcase
    return name;
  endfunction

endpackage

// File: rtl/wb_slave_timeout.sv
// Backend watchdog: counts cycles while enabled and pulses expired_o on the
// cycle the count reaches TIMEOUT-1. TIMEOUT=0 never expires.
module wb_slave_timeout #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt_q;

  // Saturates at LAST so a stalled enable never wraps back to zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired_o = (TIMEOUT != 0) && en_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/wb_slave_interface.sv
// Wishbone classic responder: turns each bus cycle into one request/response
// exchange on a simple backend port, with window decode and a backend timeout.
module wb_slave_interface
  import wb_slave_interface_pkg::*;
#(
  parameter int unsigned    dw        = 32,
  parameter int unsigned    aw        = 32,
  parameter logic [aw-1:0]  BASE_ADDR = '0,
  parameter logic [aw-1:0]  ADDR_SIZE = aw'(32'h1000),
  parameter int unsigned    TIMEOUT   = 16,
  parameter bit             DEBUG     = 1'b0
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic [aw-1:0] wb_adr_i,
  input  logic [dw-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [dw-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o,
  output logic          req_valid,
  output logic [aw-1:0] req_addr,
  output logic          req_we,
  output logic [3:0]    req_sel,
  output logic [dw-1:0] req_wdata,
  input  logic          rsp_valid,
  input  logic [dw-1:0] rsp_rdata,
  input  logic          rsp_err,
  output logic          busy
);

  // One extra bit keeps BASE_ADDR+ADDR_SIZE from wrapping at the top of memory.
  localparam logic [aw:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [aw:0] WIN_HI = {1'b0, BASE_ADDR} + {1'b0, ADDR_SIZE};

  state_e        state_q;
  logic          ack_q, err_q, busy_q;
  logic          req_valid_q, req_we_q;
  logic [aw-1:0] req_addr_q;
  logic [3:0]    req_sel_q;
  logic [dw-1:0] req_wdata_q, dat_q;

  logic [aw:0]   adr_ext;
  logic          addr_hit;
  logic          tmo_expired;
  term_e         req_term;
  logic          unused_ok;

  assign adr_ext   = {1'b0, wb_adr_i};
  assign addr_hit  = (adr_ext >= WIN_LO) && (adr_ext < WIN_HI);
  assign req_term  = (rsp_valid && !rsp_err) ? ACK : ERR;
  assign unused_ok = ^{wb_cti_i, wb_bte_i};

  wb_slave_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (wb_clk),
    .rst_ni    (wb_rst_n),
    .clear_i   (state_q != REQ),
    .en_i      (state_q == REQ),
    .expired_o (tmo_expired)
  );

  // A response arriving on the timeout cycle still decides ack vs err.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_sel_q   <= '0;
      req_wdata_q <= '0;
      dat_q       <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            busy_q <= 1'b1;
            if (addr_hit) begin
              state_q     <= REQ;
              req_valid_q <= 1'b1;
              req_addr_q  <= wb_adr_i - BASE_ADDR;
              req_we_q    <= wb_we_i;
              req_sel_q   <= wb_sel_i;
              req_wdata_q <= wb_dat_i;
              dat_q       <= '0;
            end else begin
              state_q <= RESP;
              err_q   <= 1'b1;
            end
          end
        end
        REQ: begin
          if (!wb_cyc_i) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (rsp_valid || tmo_expired) begin
            state_q     <= RESP;
            req_valid_q <= 1'b0;
            ack_q       <= (req_term == ACK);
            err_q       <= (req_term == ERR);
            if ((req_term == ACK) && !req_we_q) begin
              dat_q <= rsp_rdata;
            end
          end
        end
        RESP: begin
          state_q <= RECOVER;
        end
        RECOVER: begin
          // The master still drives stb this cycle after seeing ack.
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign wb_dat_o  = dat_q;
  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign wb_rty_o  = 1'b0;
  assign req_valid = req_valid_q;
  assign req_addr  = req_addr_q;
  assign req_we    = req_we_q;
  assign req_sel   = req_sel_q;
  assign req_wdata = req_wdata_q;
  assign busy      = busy_q;

  if (DEBUG) begin : g_debug
    logic [55:0] dbg_state_unused;
    assign dbg_state_unused = state_name(state_q);
  end

endmodule

// File: tb/tb_wb_slave_interface.sv
// Self-checking bench for wb_slave_interface: directed scenarios plus random
// transactions compared against a cycle-count model of the bus protocol.
module tb_wb_slave_interface;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] SIZE = 32'h0000_1000;
  localparam int          TMO  = 16;

  logic        wb_clk, wb_rst_n;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic        wb_ack_o, wb_err_o, wb_rty_o;
  logic        req_valid, req_we, rsp_valid, rsp_err, busy;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_sel;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_dat;

  int          obs_rise_k, obs_rise_cnt, obs_term_k, obs_ack, obs_err, obs_both;
  logic [31:0] obs_addr, obs_wdata, obs_dat;
  logic [3:0]  obs_sel;
  logic        obs_we, obs_busy_end, obs_req_term, obs_req_next;

  wb_slave_interface #(
    .dw(32), .aw(32), .BASE_ADDR(BASE), .ADDR_SIZE(SIZE), .TIMEOUT(TMO), .DEBUG(1'b1)
  ) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .req_valid(req_valid), .req_addr(req_addr),
    .req_we(req_we), .req_sel(req_sel), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit in_window(input logic [31:0] a);
    longint unsigned x, lo, hi;
    x  = a;
    lo = BASE;
    hi = lo + SIZE;
    return (x >= lo) && (x < hi);
  endfunction

  // Hit outcome: a response d cycles after req_valid rises terminates at d+1,
  // unless that is later than the timeout, which always errs at TMO.
  function automatic void model_hit(input int d, input logic rerr,
                                    output int expK, output logic expAck);
    if (d >= 0 && d + 1 <= TMO) begin
      expK   = d + 1;
      expAck = !rerr;
    end else begin
      expK   = TMO;
      expAck = 1'b0;
    end
  endfunction

  // Master + backend driver; k counts edges from the one sampling cyc/stb.
  task automatic run_txn(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                         input logic [3:0] sel, input int delay, input logic rerr,
                         input logic [31:0] rdata, input int abortAfter,
                         input logic late, input logic hold);
    int endK;
    bit done;
    logic prevReq;
    obs_rise_k = -1; obs_rise_cnt = 0; obs_term_k = -1;
    obs_ack = 0; obs_err = 0; obs_both = 0;
    obs_addr = '0; obs_wdata = '0; obs_sel = '0; obs_we = 1'b0; obs_dat = '0;
    obs_busy_end = 1'b1; obs_req_term = 1'b1; obs_req_next = 1'b1;
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = wdat; wb_sel_i = sel;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; rsp_valid = 1'b0;
    endK = -1; done = 1'b0; prevReq = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      @(posedge wb_clk); #1;
      rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = $urandom();
      if (req_valid && !prevReq) begin
        obs_rise_cnt++;
        if (obs_rise_k < 0) begin
          obs_rise_k = k; obs_addr = req_addr; obs_wdata = req_wdata;
          obs_sel = req_sel; obs_we = req_we;
        end
      end
      prevReq = req_valid;
      if (wb_ack_o && wb_err_o) obs_both++;
      if (wb_ack_o) obs_ack++;
      if (wb_err_o) obs_err++;
      if ((wb_ack_o || wb_err_o) && endK < 0) begin
        obs_term_k = k; obs_dat = wb_dat_o; obs_req_term = req_valid; endK = k;
      end
      if (abortAfter >= 0 && obs_rise_k >= 0 && endK < 0 && k == obs_rise_k + abortAfter) begin
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; endK = k;
      end
      if (delay >= 0 && obs_rise_k >= 0 && k == obs_rise_k + delay) begin
        rsp_valid = 1'b1; rsp_err = rerr; rsp_rdata = rdata;
      end
      if (late && endK >= 0 && k == endK + 1) rsp_valid = 1'b1;
      if (endK >= 0 && k == endK + 1) obs_req_next = req_valid;
      if (endK >= 0 && k == endK + 2) begin
        obs_busy_end = busy;
        if (hold) done = 1'b1;
        else begin
          wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        end
      end
      if (endK >= 0 && k == endK + 5) done = 1'b1;
    end
    rsp_valid = 1'b0; rsp_err = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    wb_rst_n = 1'b0; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = 3'b010; wb_bte_i = 2'b01;
    rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
    repeat (2) @(posedge wb_clk);
    #1;
    checks++;
    if ({wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o, req_valid, req_addr, req_we, req_sel, req_wdata, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got dat=%h ack=%b err=%b req_valid=%b busy=%b expected all zero",
               wb_dat_o, wb_ack_o, wb_err_o, req_valid, busy);
    end
    wb_rst_n = 1'b1;
    model_dat = '0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      rsp_valid = (i == 1); rsp_rdata = 32'hFFFF_0000;
      @(posedge wb_clk); #1;
      if (wb_ack_o || wb_err_o || req_valid || busy || wb_dat_o != 32'h0) seen++;
    end
    rsp_valid = 1'b0;
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("[TB] FAIL idle_rsp_ignored: got %0d active cycles expected 0", seen);
    end
  endtask

  task automatic test_write();
    run_txn(BASE + 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 2, 1'b0, 32'hA5A5_A5A5, -1, 1'b0, 1'b0);
    model_dat = '0;
    checks++;
    if ({obs_addr, obs_wdata, obs_sel, obs_we} !== {32'h10, 32'hDEADBEEF, 4'hF, 1'b1}) begin
      errors++;
      $display("[TB] FAIL write_req: got addr=%h wdata=%h sel=%h we=%b expected 00000010 deadbeef f 1",
               obs_addr, obs_wdata, obs_sel, obs_we);
    end
    checks++;
    if ({obs_term_k, obs_ack, obs_err} !== {32'd3, 32'd1, 32'd0}) begin
      errors++;
      $display("[TB] FAIL write_term: got k=%0d ack=%0d err=%0d expected k=3 ack=1 err=0",
               obs_term_k, obs_ack, obs_err);
    end
    checks++;
    if (obs_dat !== model_dat) begin
      errors++;
      $display("[TB] FAIL write_dat: got %h expected %h", obs_dat, model_dat);
    end
  endtask

  task automatic test_read();
    run_txn(BASE + 32'h20, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h12345678, -1, 1'b0, 1'b0);
    model_dat = 32'h12345678;
    checks++;
    if ({obs_term_k, obs_ack, obs_err} !== {32'd1, 32'd1, 32'd0}) begin
      errors++;
      $display("[TB] FAIL read_term: got k=%0d ack=%0d err=%0d expected k=1 ack=1 err=0",
               obs_term_k, obs_ack, obs_err);
    end
    checks++;
    if (obs_dat !== model_dat) begin
      errors++;
      $display("[TB] FAIL read_dat: got %h expected %h", obs_dat, model_dat);
    end
    checks++;
    if ({obs_busy_end, obs_req_term, obs_addr} !== {1'b0, 1'b0, 32'h20}) begin
      errors++;
      $display("[TB] FAIL read_idle: got busy=%b req_valid=%b addr=%h expected 0 0 00000020",
               obs_busy_end, obs_req_term, obs_addr);
    end
  endtask

  task automatic test_miss();
    run_txn(BASE + SIZE, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h5555_AAAA, -1, 1'b0, 1'b0);
    checks++;
    if ({obs_term_k, obs_ack, obs_err, obs_rise_cnt} !== {32'd0, 32'd0, 32'd1, 32'd0}) begin
      errors++;
      $display("[TB] FAIL miss_term: got k=%0d ack=%0d err=%0d reqs=%0d expected k=0 ack=0 err=1 reqs=0",
               obs_term_k, obs_ack, obs_err, obs_rise_cnt);
    end
    checks++;
    if (obs_dat !== model_dat) begin
      errors++;
      $display("[TB] FAIL miss_dat_hold: got %h expected %h", obs_dat, model_dat);
    end
  endtask

  task automatic test_timeout();
    int   tDelay[4] = '{-1, TMO - 1, TMO, 4};
    logic tErr[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic tLate[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    int   expK;
    logic expAck;
    logic [31:0] rd;
    for (int i = 0; i < 4; i++) begin
      rd = $urandom();
      run_txn(BASE + 32'h100 + 32'(i * 4), 1'b0, 32'h0, 4'hF, tDelay[i], tErr[i], rd, -1, tLate[i], 1'b0);
      model_hit(tDelay[i], tErr[i], expK, expAck);
      model_dat = expAck ? rd : 32'h0;
      checks++;
      if ({obs_term_k, obs_ack, obs_err, obs_both} !== {expK, int'(expAck), int'(!expAck), 0}) begin
        errors++;
        $display("[TB] FAIL timeout%0d_term: got k=%0d ack=%0d err=%0d both=%0d expected k=%0d ack=%0d err=%0d",
                 i, obs_term_k, obs_ack, obs_err, obs_both, expK, expAck, !expAck);
      end
      checks++;
      if ({obs_dat, obs_req_term, obs_rise_k} !== {model_dat, 1'b0, 0}) begin
        errors++;
        $display("[TB] FAIL timeout%0d_misc: got dat=%h req_valid=%b rise=%0d expected dat=%h 0 0",
                 i, obs_dat, obs_req_term, obs_rise_k, model_dat);
      end
    end
  endtask

  task automatic test_abort();
    run_txn(BASE + 32'h80, 1'b0, 32'h0, 4'hF, -1, 1'b0, 32'h0, 3, 1'b1, 1'b0);
    model_dat = '0;
    checks++;
    if ({obs_rise_k, obs_ack, obs_err} !== {0, 0, 0}) begin
      errors++;
      $display("[TB] FAIL abort_term: got rise=%0d ack=%0d err=%0d expected 0 0 0", obs_rise_k, obs_ack, obs_err);
    end
    checks++;
    if ({obs_req_next, obs_busy_end, wb_dat_o} !== {1'b0, 1'b0, model_dat}) begin
      errors++;
      $display("[TB] FAIL abort_state: got req_valid=%b busy=%b dat=%h expected 0 0 %h",
               obs_req_next, obs_busy_end, wb_dat_o, model_dat);
    end
  endtask

  task automatic test_back_to_back();
    run_txn(BASE + 32'h40, 1'b0, 32'h0, 4'hF, 1, 1'b0, 32'hCAFEF00D, -1, 1'b0, 1'b1);
    model_dat = 32'hCAFEF00D;
    checks++;
    if ({obs_rise_cnt, obs_term_k, obs_ack, obs_dat, obs_busy_end} !== {1, 2, 1, model_dat, 1'b0}) begin
      errors++;
      $display("[TB] FAIL b2b_read: got reqs=%0d k=%0d ack=%0d dat=%h busy=%b expected 1 2 1 %h 0",
               obs_rise_cnt, obs_term_k, obs_ack, obs_dat, obs_busy_end, model_dat);
    end
    run_txn(BASE + 32'h44, 1'b1, 32'h0BADC0DE, 4'h3, 0, 1'b0, 32'h7777_7777, -1, 1'b0, 1'b0);
    model_dat = '0;
    checks++;
    if ({obs_rise_k, obs_rise_cnt, obs_addr, obs_wdata, obs_sel} !== {0, 1, 32'h44, 32'h0BADC0DE, 4'h3}) begin
      errors++;
      $display("[TB] FAIL b2b_write_req: got rise=%0d reqs=%0d addr=%h wdata=%h sel=%h expected 0 1 00000044 0badc0de 3",
               obs_rise_k, obs_rise_cnt, obs_addr, obs_wdata, obs_sel);
    end
    checks++;
    if ({obs_term_k, obs_ack, obs_err, obs_dat} !== {1, 1, 0, model_dat}) begin
      errors++;
      $display("[TB] FAIL b2b_write_term: got k=%0d ack=%0d err=%0d dat=%h expected 1 1 0 %h",
               obs_term_k, obs_ack, obs_err, obs_dat, model_dat);
    end
  endtask

  task automatic test_async_reset();
    int seen;
    wb_adr_i = BASE + 32'h200; wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_dat_i = $urandom();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; rsp_valid = 1'b0;
    repeat (3) @(posedge wb_clk);
    #1;
    checks++;
    if (req_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL areset_pre_req: got req_valid=%b expected 1", req_valid);
    end
    #2 wb_rst_n = 1'b0;
    #1;
    checks++;
    if ({wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o, req_valid, req_addr, req_we, req_sel, req_wdata, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL areset_outputs: got req_valid=%b addr=%h busy=%b ack=%b err=%b expected all zero",
               req_valid, req_addr, busy, wb_ack_o, wb_err_o);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge wb_clk); #1;
    wb_rst_n = 1'b1;
    model_dat = '0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge wb_clk); #1;
      if (wb_ack_o || wb_err_o || req_valid || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("[TB] FAIL areset_discard: got %0d active cycles expected 0", seen);
    end
  endtask

  task automatic test_random();
    logic [31:0] adr, wdat, rd;
    logic [3:0]  sel;
    logic        we, rerr, expHit, expAck;
    int          d, expK;
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 5))
        0:       adr = BASE - 32'd1;
        1:       adr = BASE + SIZE - 32'd1;
        2:       adr = BASE + SIZE;
        3:       adr = BASE;
        4:       adr = BASE + $urandom_range(0, SIZE - 1);
        default: adr = $urandom();
      endcase
      we = $urandom_range(0, 1); wdat = $urandom(); sel = $urandom_range(0, 15); rd = $urandom();
      rerr = ($urandom_range(0, 4) == 0);
      d = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TMO + 2));
      run_txn(adr, we, wdat, sel, d, rerr, rd, -1, 1'b0, 1'b0);
      expHit = in_window(adr);
      if (expHit) begin
        model_hit(d, rerr, expK, expAck);
        model_dat = (expAck && !we) ? rd : 32'h0;
      end else begin
        expK = 0; expAck = 1'b0;
      end
      checks++;
      if ({obs_term_k, obs_ack, obs_err, obs_both} !== {expK, int'(expAck), int'(!expAck), 0}) begin
        errors++;
        $display("[TB] FAIL rand%0d_term: adr=%h got k=%0d ack=%0d err=%0d both=%0d expected k=%0d ack=%0d err=%0d",
                 n, adr, obs_term_k, obs_ack, obs_err, obs_both, expK, expAck, !expAck);
      end
      checks++;
      if ({obs_dat, obs_busy_end, obs_rise_cnt} !== {model_dat, 1'b0, int'(expHit)}) begin
        errors++;
        $display("[TB] FAIL rand%0d_state: got dat=%h busy=%b reqs=%0d expected %h 0 %0d",
                 n, obs_dat, obs_busy_end, obs_rise_cnt, model_dat, expHit);
      end
      if (expHit) begin
        checks++;
        if ({obs_addr, obs_wdata, obs_sel, obs_we} !== {adr - BASE, wdat, sel, we}) begin
          errors++;
          $display("[TB] FAIL rand%0d_req: got addr=%h wdata=%h sel=%h we=%b expected %h %h %h %b",
                   n, obs_addr, obs_wdata, obs_sel, obs_we, adr - BASE, wdat, sel, we);
        end
      end
    end
  endtask

  initial begin
    $display("[TB] starting wb_slave_interface bench");
    test_reset();
    test_write();
    test_read();
    test_miss();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_slave_interface.md
Name: wb_slave_interface

Overview:
- Wishbone classic responder (slave) that terminates cycles from the team's Wishbone bus master.
- Converts each bus cycle into a single request/response transaction on a simple local backend port (register banks, peripheral cores).
- Checks the address window, times out silent backends, and supplies ack/err termination.
- Treats every cycle as a single access regardless of wb_cti_i/wb_bte_i.

Parameters:
- dw, 32, data width.
- aw, 32, address width.
- BASE_ADDR, 0, first byte address decoded by this slave.
- ADDR_SIZE, 32'h1000, window size in bytes; a hit requires BASE_ADDR <= adr < BASE_ADDR+ADDR_SIZE.
- TIMEOUT, 16, backend cycles allowed before err; 0 disables the timeout.
- DEBUG, 0, enables simulation-only state-name decode.

Ports:
- wb_clk  in  1  clock
- wb_rst_n  in  1  asynchronous active-low reset
- wb_adr_i  in  aw  bus address
- wb_dat_i  in  dw  write data
- wb_sel_i  in  4  byte selects
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  cycle valid
- wb_stb_i  in  1  strobe
- wb_cti_i  in  3  cycle type (ignored)
- wb_bte_i  in  2  burst type (ignored)
- wb_dat_o  out  dw  read data
- wb_ack_o  out  1  normal termination
- wb_err_o  out  1  error termination
- wb_rty_o  out  1  retry; constant 0
- req_valid  out  1  backend request pending
- req_addr  out  aw  wb_adr_i minus BASE_ADDR
- req_we  out  1  request is a write
- req_sel  out  4  byte selects
- req_wdata  out  dw  write data
- rsp_valid  in  1  backend completion, one-cycle pulse
- rsp_rdata  in  dw  read data, valid with rsp_valid
- rsp_err  in  1  backend error, valid with rsp_valid
- busy  out  1  state != IDLE

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While wb_rst_n=0 every output is 0 and the state is IDLE. Reset deasserted mid-transaction discards the transaction; no ack/err is issued.
- All outputs are registered.
- States:
  - IDLE: on cyc&stb, latch adr/we/sel/dat. Window hit -> REQ with req_valid=1 from the next edge. Miss -> RESP with wb_err_o=1 from the next edge; the backend is not touched.
  - REQ: req_* held stable; timeout counter increments each cycle.
    - rsp_valid&!rsp_err -> RESP with wb_ack_o=1; on a read, wb_dat_o<=rsp_rdata.
    - rsp_valid&rsp_err -> RESP with wb_err_o=1.
    - Counter reaches TIMEOUT-1 without rsp_valid -> RESP with wb_err_o=1, req_valid dropped.
    - rsp_valid on the same cycle as the timeout wins (ack/err from rsp).
    - cyc_i drops -> IDLE, req_valid=0, no termination.
  - RESP: ack or err high for exactly one cycle. Next state is RECOVER.
  - RECOVER: one cycle; stb is ignored because the master's outputs remain asserted for one cycle after it samples ack. Next state is IDLE.
- req_valid deasserts on the edge that enters RESP.
- rsp_valid in IDLE/RESP/RECOVER is ignored; a late response after an abort is dropped.
- wb_dat_o is cleared to 0 on entry to REQ and holds its value after ack until the next read. Writes leave wb_dat_o at 0.
- Minimum latency for a hit with a zero-latency backend (rsp_valid the cycle req_valid rises): cyc/stb sampled at edge N, ack high at N+2, back in IDLE at N+4. Minimum latency for a miss: err at N+1.
- ack and err are never high together.
- Address arithmetic is done at aw+1 bits so that BASE_ADDR+ADDR_SIZE does not wrap.

Decomposition:
- Shared package: state encodings (IDLE=0, REQ=1, RESP=2, RECOVER=3) and the termination-type constants (ACK, ERR).
- One natural sub-module: wb_slave_timeout. It is a counter with clear/enable inputs, parameterised by TIMEOUT, and outputs an expired pulse.

Test Plan:
- Write: adr=BASE+0x10, dat=0xDEADBEEF, sel=0xF; backend responds 2 cycles after req_valid -> req_addr=0x10, req_wdata=0xDEADBEEF, one ack pulse, err=0.
- Read: adr=BASE+0x20; backend returns rsp_rdata=0x12345678 -> wb_dat_o=0x12345678 in the ack cycle; the master's data_rd captures it.
- Out of window: adr=BASE+0x1000 -> err at N+1, req_valid never asserted.
- Silent backend, TIMEOUT=16 -> err exactly 16 cycles after req_valid rises; a late rsp_valid is ignored. Repeat with rsp_err=1 -> err, no ack.
- Abort: drop cyc after 3 cycles in REQ -> req_valid=0 the next edge, no ack/err, busy=0. Then a back-to-back master read/write pair -> two clean terminations, and RECOVER prevents a duplicate request.
- Assert wb_rst_n=0 while in REQ -> all outputs 0 immediately, without waiting for a clock edge.
